// File: rtl/ROM_pkg.sv
// Lane geometry constants and shared types for the enemy trajectory controller.
package ROM_pkg;

  localparam int NUM_LANES = 3;

  localparam int X_ENEMY1_START = 240;

  localparam int Y_ENEMY1_BASE1 = 100;
  localparam int Y_ENEMY2_BASE2 = 150;
  localparam int Y_ENEMY3_BASE3 = 200;

  localparam int X_BASE1 = 50;
  localparam int X_BASE2 = 40;
  localparam int X_BASE3 = 60;

  typedef enum logic [1:0] {
    E_IDLE,
    E_FLY,
    E_ARRIVE,
    E_BOOM
  } enemy_state_t;

  function automatic int lane_y(input int lane);
    case (lane)
      0:       return Y_ENEMY1_BASE1;
      1:       return Y_ENEMY2_BASE2;
      default: return Y_ENEMY3_BASE3;
    endcase
  endfunction

  function automatic int lane_x_end(input int lane);
    case (lane)
      0:       return X_BASE1;
      1:       return X_BASE2;
      default: return X_BASE3;
    endcase
  endfunction

endpackage

// File: rtl/enemy_path_ctl_if.sv
// Spawn/kill handshake and per-lane sprite outputs between game logic and the enemy controller.
interface enemy_path_ctl_if;
  logic        frame_tick;
  logic [2:0]  spawn_req;
  logic [2:0]  spawn_rdy;
  logic [2:0]  kill;
  logic [23:0] enemy_x;
  logic [23:0] enemy_y;
  logic [2:0]  enemy_active;
  logic [2:0]  enemy_boom;
  logic [2:0]  base_hit;

  modport master (
    output frame_tick, spawn_req, kill,
    input  spawn_rdy, enemy_x, enemy_y, enemy_active, enemy_boom, base_hit
  );

  modport slave (
    input  frame_tick, spawn_req, kill,
    output spawn_rdy, enemy_x, enemy_y, enemy_active, enemy_boom, base_hit
  );
endinterface

// File: rtl/enemy_path_ctl_lane.sv
// Single-lane enemy FSM: spawn, step-left flight, base arrival, kill (explosion with ENEMY_EXPLODE_EN).
module enemy_lane
  import ROM_pkg::*;
#(
  parameter int X_START         = 240,
  parameter int X_END           = 50,
  parameter int Y               = 100,
  parameter int FRAMES_PER_STEP = 4,
  parameter int EXPLODE_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn_req,
  input  logic       kill,
  output logic       spawn_rdy,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       active,
  output logic       boom,
  output logic       base_hit
);

  // One frame counter serves both the step divider and the explosion timer.
  localparam int CNT_MAX = (FRAMES_PER_STEP > EXPLODE_FRAMES) ? FRAMES_PER_STEP : EXPLODE_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] STEP_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]    XS        = 8'(X_START);
  localparam logic [7:0]    XE        = 8'(X_END);
`ifdef ENEMY_EXPLODE_EN
  localparam logic [CW-1:0] BOOM_LAST = CW'(EXPLODE_FRAMES - 1);
`endif

  enemy_state_t  state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          boom_q, boom_d;
  logic          hit_q, hit_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    boom_d   = boom_q;
    hit_d    = 1'b0;
    rdy_d    = rdy_q;
    unique case (state_q)
      E_IDLE: begin
        if (spawn_req) begin
          state_d  = E_FLY;
          x_d      = XS;
          cnt_d    = '0;
          active_d = 1'b1;
          rdy_d    = 1'b0;
        end
      end
      E_FLY: begin
        // Kill is checked first so it beats a coincident final step.
        if (kill) begin
`ifdef ENEMY_EXPLODE_EN
          state_d = E_BOOM;
          boom_d  = 1'b1;
          cnt_d   = '0;
`else
          state_d  = E_IDLE;
          active_d = 1'b0;
          rdy_d    = 1'b1;
`endif
        end else if (frame_tick) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            x_d   = x_q - 8'd1;
            if (x_d == XE) begin
              state_d  = E_ARRIVE;
              hit_d    = 1'b1;
              active_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      E_ARRIVE: begin
        state_d = E_IDLE;
        rdy_d   = 1'b1;
      end
      E_BOOM: begin
`ifdef ENEMY_EXPLODE_EN
        if (frame_tick) begin
          if (cnt_q == BOOM_LAST) begin
            state_d  = E_IDLE;
            cnt_d    = '0;
            active_d = 1'b0;
            boom_d   = 1'b0;
            rdy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`else
        state_d  = E_IDLE;
        active_d = 1'b0;
        boom_d   = 1'b0;
        rdy_d    = 1'b1;
`endif
      end
      default: state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= E_IDLE;
      x_q      <= XS;
      cnt_q    <= '0;
      active_q <= 1'b0;
      boom_q   <= 1'b0;
      hit_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      boom_q   <= boom_d;
      hit_q    <= hit_d;
      rdy_q    <= rdy_d;
    end
  end

  assign spawn_rdy = rdy_q;
  assign x         = x_q;
  assign y         = 8'(Y);
  assign active    = active_q;
  assign boom      = boom_q;
  assign base_hit  = hit_q;

endmodule

// File: rtl/enemy_path_ctl.sv
// Three-lane enemy trajectory controller; each lane is an independent enemy_lane instance.
// Optional explosion phase on kill enabled by defining ENEMY_EXPLODE_EN.
module enemy_path_ctl
  import ROM_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int X_START         = X_ENEMY1_START,
  parameter int EXPLODE_FRAMES  = 30
) (
  input logic             clk,
  input logic             rst,
  enemy_path_ctl_if.slave bus
);

  logic [23:0] x_all;
  logic [23:0] y_all;
  logic [2:0]  rdy_all;
  logic [2:0]  active_all;
  logic [2:0]  boom_all;
  logic [2:0]  hit_all;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    enemy_lane #(
      .X_START        (X_START),
      .X_END          (lane_x_end(i)),
      .Y              (lane_y(i)),
      .FRAMES_PER_STEP(FRAMES_PER_STEP),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .frame_tick(bus.frame_tick),
      .spawn_req (bus.spawn_req[i]),
      .kill      (bus.kill[i]),
      .spawn_rdy (rdy_all[i]),
      .x         (x_all[8*i +: 8]),
      .y         (y_all[8*i +: 8]),
      .active    (active_all[i]),
      .boom      (boom_all[i]),
      .base_hit  (hit_all[i])
    );
  end

  assign bus.spawn_rdy    = rdy_all;
  assign bus.enemy_x      = x_all;
  assign bus.enemy_y      = y_all;
  assign bus.enemy_active = active_all;
  assign bus.enemy_boom   = boom_all;
  assign bus.base_hit     = hit_all;

endmodule

// File: tb/tb_enemy_path_ctl.sv
// Self-checking bench for enemy_path_ctl: directed scenarios plus randomized traffic vs. a position model.
module tb_enemy_path_ctl;

  localparam int FPS = 4;
  localparam int XS  = 240;
  localparam int EF  = 30;

  int XEND [3] = '{50, 40, 60};
  int YC   [3] = '{100, 150, 200};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_path_ctl_if bus();

  enemy_path_ctl #(
    .FRAMES_PER_STEP(FPS),
    .X_START        (XS),
    .EXPLODE_FRAMES (EF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: flight progress as frame ticks since spawn; position derived by division.
  bit         m_fly  [3];
  bit         m_arr  [3];
  bit         m_expl [3];
  int         m_t    [3];
  int         m_bt   [3];
  logic [7:0] m_x    [3];

  task automatic model_update(input logic [2:0] sp, input logic [2:0] kl, input logic ft, input logic r);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_fly[i] = 0; m_arr[i] = 0; m_expl[i] = 0;
        m_t[i] = 0; m_bt[i] = 0; m_x[i] = 8'(XS);
      end else if (m_fly[i]) begin
        if (kl[i]) begin
          m_fly[i] = 0;
`ifdef ENEMY_EXPLODE_EN
          m_expl[i] = 1; m_bt[i] = 0;
`endif
        end else if (ft) begin
          m_t[i]++;
          m_x[i] = 8'(XS - m_t[i] / FPS);
          if (int'(m_x[i]) == XEND[i]) begin
            m_fly[i] = 0; m_arr[i] = 1;
          end
        end
      end else if (m_arr[i]) begin
        m_arr[i] = 0;
      end else if (m_expl[i]) begin
        if (ft) begin
          m_bt[i]++;
          if (m_bt[i] == EF) m_expl[i] = 0;
        end
      end else if (sp[i]) begin
        m_fly[i] = 1; m_t[i] = 0; m_x[i] = 8'(XS);
      end
    end
  endtask

  task automatic cycle(input logic [2:0] sp, input logic [2:0] kl, input logic ft, input logic r);
    rst = r;
    bus.spawn_req  = sp;
    bus.kill       = kl;
    bus.frame_tick = ft;
    @(posedge clk);
    model_update(sp, kl, ft, r);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cycle(3'b000, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    checks++; if (bus.spawn_rdy !== 3'b111) begin failures++; $display("FAIL reset_rdy got=%b exp=111", bus.spawn_rdy); end
    checks++; if (bus.enemy_active !== 3'b000) begin failures++; $display("FAIL reset_active got=%b exp=000", bus.enemy_active); end
    checks++; if (bus.enemy_boom !== 3'b000) begin failures++; $display("FAIL reset_boom got=%b exp=000", bus.enemy_boom); end
    checks++; if (bus.base_hit !== 3'b000) begin failures++; $display("FAIL reset_hit got=%b exp=000", bus.base_hit); end
    checks++; if (bus.enemy_x !== {8'd240, 8'd240, 8'd240}) begin failures++; $display("FAIL reset_x got=%h exp=f0f0f0", bus.enemy_x); end
    checks++; if (bus.enemy_y !== {8'd200, 8'd150, 8'd100}) begin failures++; $display("FAIL reset_y got=%h exp=c89664", bus.enemy_y); end
  endtask

  task automatic test_spawn();
    cycle(3'b001, 3'b000, 1'b0, 1'b0);
    checks++; if (bus.enemy_active !== 3'b001) begin failures++; $display("FAIL spawn_active got=%b exp=001", bus.enemy_active); end
    checks++; if (bus.enemy_x[7:0] !== 8'd240) begin failures++; $display("FAIL spawn_x got=%0d exp=240", bus.enemy_x[7:0]); end
    checks++; if (bus.spawn_rdy !== 3'b110) begin failures++; $display("FAIL spawn_rdy got=%b exp=110", bus.spawn_rdy); end
    checks++; if (bus.enemy_y[7:0] !== 8'd100) begin failures++; $display("FAIL spawn_y got=%0d exp=100", bus.enemy_y[7:0]); end
  endtask

  task automatic test_flight();
    ticks(8);
    checks++; if (bus.enemy_x[7:0] !== 8'd238) begin failures++; $display("FAIL flight_x8 got=%0d exp=238", bus.enemy_x[7:0]); end
    ticks(751);
    checks++; if (bus.base_hit !== 3'b000) begin failures++; $display("FAIL flight_early_hit got=%b exp=000", bus.base_hit); end
    checks++; if (bus.enemy_x[7:0] !== 8'd51) begin failures++; $display("FAIL flight_x759 got=%0d exp=51", bus.enemy_x[7:0]); end
    ticks(1);
    checks++; if (bus.base_hit !== 3'b001) begin failures++; $display("FAIL flight_hit got=%b exp=001", bus.base_hit); end
    checks++; if (bus.enemy_x[7:0] !== 8'd50) begin failures++; $display("FAIL flight_x_end got=%0d exp=50", bus.enemy_x[7:0]); end
    checks++; if (bus.enemy_active[0] !== 1'b0) begin failures++; $display("FAIL flight_active_arr got=%b exp=0", bus.enemy_active[0]); end
    ticks(1);
    checks++; if (bus.base_hit !== 3'b000) begin failures++; $display("FAIL flight_hit_pulse got=%b exp=000", bus.base_hit); end
    checks++; if (bus.spawn_rdy[0] !== 1'b1) begin failures++; $display("FAIL flight_rdy_after got=%b exp=1", bus.spawn_rdy[0]); end
    ticks(8);
    checks++; if (bus.enemy_x[7:0] !== 8'd50) begin failures++; $display("FAIL flight_x_hold got=%0d exp=50", bus.enemy_x[7:0]); end
  endtask

  task automatic test_kill_final();
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b010, 3'b000, 1'b0, 1'b0);
    ticks(799);
    checks++; if (bus.enemy_x[15:8] !== 8'd41) begin failures++; $display("FAIL kf_x41 got=%0d exp=41", bus.enemy_x[15:8]); end
    cycle(3'b000, 3'b010, 1'b1, 1'b0);
    checks++; if (bus.base_hit[1] !== 1'b0) begin failures++; $display("FAIL kf_no_hit got=%b exp=0", bus.base_hit[1]); end
`ifdef ENEMY_EXPLODE_EN
    checks++; if (bus.enemy_boom[1] !== 1'b1) begin failures++; $display("FAIL kf_boom got=%b exp=1", bus.enemy_boom[1]); end
    checks++; if (bus.enemy_x[15:8] !== 8'd41) begin failures++; $display("FAIL kf_x_frozen got=%0d exp=41", bus.enemy_x[15:8]); end
`else
    checks++; if (bus.enemy_active[1] !== 1'b0) begin failures++; $display("FAIL kf_active got=%b exp=0", bus.enemy_active[1]); end
    checks++; if (bus.spawn_rdy[1] !== 1'b1) begin failures++; $display("FAIL kf_rdy got=%b exp=1", bus.spawn_rdy[1]); end
`endif
    ticks(2);
    checks++; if (bus.base_hit !== 3'b000) begin failures++; $display("FAIL kf_no_hit_late got=%b exp=000", bus.base_hit); end
  endtask

  task automatic test_boom();
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b100, 3'b000, 1'b0, 1'b0);
    ticks(480);
    checks++; if (bus.enemy_x[23:16] !== 8'd120) begin failures++; $display("FAIL boom_x120 got=%0d exp=120", bus.enemy_x[23:16]); end
    cycle(3'b000, 3'b100, 1'b0, 1'b0);
`ifdef ENEMY_EXPLODE_EN
    checks++; if (bus.enemy_boom[2] !== 1'b1) begin failures++; $display("FAIL boom_on got=%b exp=1", bus.enemy_boom[2]); end
    checks++; if (bus.enemy_active[2] !== 1'b1) begin failures++; $display("FAIL boom_active got=%b exp=1", bus.enemy_active[2]); end
    checks++; if (bus.spawn_rdy[2] !== 1'b0) begin failures++; $display("FAIL boom_rdy got=%b exp=0", bus.spawn_rdy[2]); end
    ticks(29);
    checks++; if (bus.enemy_boom[2] !== 1'b1) begin failures++; $display("FAIL boom_29 got=%b exp=1", bus.enemy_boom[2]); end
    checks++; if (bus.enemy_x[23:16] !== 8'd120) begin failures++; $display("FAIL boom_x_frozen got=%0d exp=120", bus.enemy_x[23:16]); end
    ticks(1);
    checks++; if (bus.enemy_boom[2] !== 1'b0) begin failures++; $display("FAIL boom_end got=%b exp=0", bus.enemy_boom[2]); end
    checks++; if (bus.spawn_rdy[2] !== 1'b1) begin failures++; $display("FAIL boom_rdy_end got=%b exp=1", bus.spawn_rdy[2]); end
`else
    checks++; if (bus.enemy_boom !== 3'b000) begin failures++; $display("FAIL boom_off got=%b exp=000", bus.enemy_boom); end
    checks++; if (bus.enemy_active[2] !== 1'b0) begin failures++; $display("FAIL boom_active got=%b exp=0", bus.enemy_active[2]); end
    checks++; if (bus.spawn_rdy[2] !== 1'b1) begin failures++; $display("FAIL boom_rdy got=%b exp=1", bus.spawn_rdy[2]); end
    ticks(30);
    checks++; if (bus.enemy_boom !== 3'b000) begin failures++; $display("FAIL boom_stays_off got=%b exp=000", bus.enemy_boom); end
`endif
  endtask

  task automatic test_multi_spawn_rst();
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b001, 3'b000, 1'b0, 1'b0);
    ticks(4);
    cycle(3'b111, 3'b000, 1'b0, 1'b0);
    checks++; if (bus.enemy_active !== 3'b111) begin failures++; $display("FAIL ms_active got=%b exp=111", bus.enemy_active); end
    checks++; if (bus.enemy_x !== {8'd240, 8'd240, 8'd239}) begin failures++; $display("FAIL ms_x got=%h exp=f0f0ef", bus.enemy_x); end
    checks++; if (bus.spawn_rdy !== 3'b000) begin failures++; $display("FAIL ms_rdy got=%b exp=000", bus.spawn_rdy); end
    ticks(40);
    cycle(3'b000, 3'b000, 1'b1, 1'b1);
    checks++; if (bus.enemy_active !== 3'b000) begin failures++; $display("FAIL rst_active got=%b exp=000", bus.enemy_active); end
    checks++; if (bus.spawn_rdy !== 3'b111) begin failures++; $display("FAIL rst_rdy got=%b exp=111", bus.spawn_rdy); end
    checks++; if (bus.enemy_x !== {8'd240, 8'd240, 8'd240}) begin failures++; $display("FAIL rst_x got=%h exp=f0f0f0", bus.enemy_x); end
    ticks(3);
    checks++; if (bus.base_hit !== 3'b000) begin failures++; $display("FAIL rst_no_hit got=%b exp=000", bus.base_hit); end
  endtask

  task automatic test_spawn_kill_idle();
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b111, 3'b111, 1'b0, 1'b0);
    checks++; if (bus.enemy_active !== 3'b111) begin failures++; $display("FAIL sk_active got=%b exp=111", bus.enemy_active); end
    checks++; if (bus.enemy_boom !== 3'b000) begin failures++; $display("FAIL sk_boom got=%b exp=000", bus.enemy_boom); end
  endtask

  task automatic test_random();
    logic [2:0]  sp, kl, e_act, e_boom, e_hit, e_rdy;
    logic [23:0] e_x;
    logic        ft, r;
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    for (int n = 0; n < 6000; n++) begin
      sp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      for (int i = 0; i < 3; i++) kl[i] = ($urandom_range(0, 1499) == 0);
      ft = ($urandom_range(0, 4) != 0);
      r  = ($urandom_range(0, 2999) == 0);
      cycle(sp, kl, ft, r);
      for (int i = 0; i < 3; i++) begin
        e_act[i]  = m_fly[i] | m_expl[i];
        e_boom[i] = m_expl[i];
        e_hit[i]  = m_arr[i];
        e_rdy[i]  = !(m_fly[i] | m_arr[i] | m_expl[i]);
        e_x[8*i +: 8] = m_x[i];
      end
      checks++; if (bus.enemy_x !== e_x) begin failures++; $display("FAIL rnd_x cyc=%0d got=%h exp=%h", n, bus.enemy_x, e_x); end
      checks++; if (bus.enemy_active !== e_act) begin failures++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", n, bus.enemy_active, e_act); end
      checks++; if (bus.enemy_boom !== e_boom) begin failures++; $display("FAIL rnd_boom cyc=%0d got=%b exp=%b", n, bus.enemy_boom, e_boom); end
      checks++; if (bus.base_hit !== e_hit) begin failures++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", n, bus.base_hit, e_hit); end
      checks++; if (bus.spawn_rdy !== e_rdy) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", n, bus.spawn_rdy, e_rdy); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.spawn_req  = 3'b000;
    bus.kill       = 3'b000;
    bus.frame_tick = 1'b0;
    test_reset();
    test_spawn();
    test_flight();
    test_kill_final();
    test_boom();
    test_multi_spawn_rst();
    test_spawn_kill_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
